tw_vector_feeder: RTL and testbench
===================================

Name: tw_vector_feeder

Overview:
- Front-end driver and result collector for the 32-lane, 4-bit pipelined adder tree (5-cycle latency, 9-bit sum `P`).
- Accepts a serial stream of 4-bit lane values over a valid/ready handshake and packs them into a flat lane bus that drives the tree's `T_w1..T_w32` inputs.
- Counts the tree latency, captures `P` for that vector, and presents it with an output valid/ready handshake.
- The tree has no valid signal of its own; this block supplies all framing.

Parameters:
- `LANES`, 32, number of lanes packed per vector.
- `NIB_W`, 4, width of each lane value.
- `SUM_W`, 9, width of the tree result.
- `TREE_LAT`, 5, register stages from lane bus to `P`.
- `CNT_W`, 5, lane counter width, equal to clog2(`LANES`).

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: block accepts a nibble this cycle.
- `in_data` input `NIB_W`: lane value; first accepted nibble goes to lane 0 (`T_w1`).
- `tw_bus` output `LANES*NIB_W`: lane k at bits [4k+3:4k]; lane 0 drives `T_w1`, lane 31 drives `T_w32`.
- `tree_p` input `SUM_W`: connected to the tree `P` output.
- `out_valid` output 1: `out_sum` valid.
- `out_ready` input 1: consumer accepts `out_sum`.
- `out_sum` output `SUM_W`: captured tree result.
- `busy` output 1: high whenever state is not FILL.

Behaviour:
- One clock `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state = FILL, lane_cnt = 0, wait_cnt = 0.
  - Lane shift register = 0, `tw_bus` = 0.
  - `out_sum` = 0, `out_valid` = 0, `busy` = 0.
  - `in_ready` = 1 once reset is released.
- Handshakes:
  - Input transfer occurs when `in_valid` & `in_ready` at a rising edge.
  - Output transfer occurs when `out_valid` & `out_ready` at a rising edge.
- FILL state:
  - `in_ready` = 1.
  - Each transfer writes `in_data` into lane `lane_cnt` and increments `lane_cnt`.
  - Gaps in `in_valid` are allowed; lane_cnt holds during gaps.
  - On the transfer with `lane_cnt` = `LANES`-1 (edge A):
    - `tw_bus` loads the complete vector, including the nibble arriving on that edge.
    - `lane_cnt` wraps to 0, `wait_cnt` clears, state -> WAIT.
- WAIT state:
  - `in_ready` = 0.
  - `wait_cnt` increments every cycle.
  - When `wait_cnt` = `TREE_LAT` (edge A+`TREE_LAT`+1): `out_sum` <= `tree_p`, `out_valid` <= 1, state -> HOLD.
  - Resulting latency: `out_valid` rises `TREE_LAT`+1 = 6 edges after the last-nibble acceptance edge.
- HOLD state:
  - `in_ready` = 0.
  - `out_sum` and `out_valid` are held stable until an output transfer.
  - On the transfer: `out_valid` <= 0, state -> FILL.
  - The first nibble of the next vector is accepted no earlier than the edge after the output transfer.
- `tw_bus` changes only on the edge that completes a vector. It holds its value through WAIT, HOLD and the next FILL, so the tree recomputes the same sum harmlessly.
- Sum width: maximum 32×15 = 480 fits in 9 bits, so no saturation or overflow handling exists.
- `in_data` is ignored whenever `in_ready` = 0.
- `out_ready` is ignored outside HOLD.
- Reset asserted mid-operation:
  - Immediate clear of all state; any partially filled vector or in-flight result is discarded.
  - `tw_bus` returns to 0.
  - The tree is reset by the same `rst_n`, so no stale result is captured afterwards.

Optional Feature:
- Macro: `TW_ZERO_PAD_EN`.
- When defined:
  - Adds input port `in_last` (1 bit).
  - An input transfer with `in_last` = 1 completes the vector early and zero-fills the remaining lanes in the same `tw_bus` load.
  - Then enters WAIT exactly as a full vector does, with `lane_cnt` reset to 0.
  - `in_last` on lane `LANES`-1 is redundant and behaves as a normal completion.
- When undefined:
  - No `in_last` port.
  - Exactly `LANES` nibbles are always required per vector.

Test Plan:
- Reset, then 32 nibbles of 15 with `in_valid` held high -> `tw_bus` = all-F after the 32nd edge; `out_valid` rises 6 edges later with `out_sum` = 480.
- Lane i = i mod 16 for i = 0..31, with `in_valid` deasserted every third cycle -> `lane_cnt` holds during gaps; `out_sum` = 240; lane 5 appears at `tw_bus[23:20]` = 5.
- Vector of all 1s with `out_ready` = 0 for 10 cycles after `out_valid` -> `out_sum` = 32 held stable; `in_ready` = 0 and `busy` = 1 throughout; FILL resumes the edge after `out_ready` = 1.
- Two back-to-back vectors (all 7s, then all 2s) -> results 224 then 64, in order, with no stale capture of 224 as the second result.
- Assert `rst_n` = 0 during WAIT (third cycle) -> `out_valid` = 0, `out_sum` = 0, `tw_bus` = 0, `in_ready` = 1 after release; a following all-3s vector yields 96.
- With `TW_ZERO_PAD_EN`: nibbles 1, 2, 3 with `in_last` on the third -> lanes 3..31 = 0; `out_sum` = 6 six edges after the third nibble.

Source files
------------

// File: rtl/tw_vector_feeder.sv
// tw_vector_feeder: packs a serial nibble stream into the 32-lane bus of the
// pipelined adder tree, waits out the tree latency, then captures and
// presents the tree sum over a valid/ready handshake.
//
// Optional feature macro: TW_ZERO_PAD_EN
//   When defined, adds in_last; a transfer with in_last = 1 completes the
//   vector early and zero-fills the remaining lanes.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | accepting nibbles, lane_cnt selects the lane being written
// WAIT  | vector on tw_bus, counting tree latency before capturing tree_p
// HOLD  | out_sum presented with out_valid, waiting for out_ready
module tw_vector_feeder #(
  parameter int LANES    = 32,
  parameter int NIB_W    = 4,
  parameter int SUM_W    = 9,
  parameter int TREE_LAT = 5,
  parameter int CNT_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W-1:0]       in_data,
`ifdef TW_ZERO_PAD_EN
  input  logic                   in_last,
`endif
  output logic [LANES*NIB_W-1:0] tw_bus,
  input  logic [SUM_W-1:0]       tree_p,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_W-1:0]       out_sum,
  output logic                   busy
);

  localparam int WAIT_W = $clog2(TREE_LAT + 1);
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(LANES - 1);
  localparam logic [WAIT_W-1:0] LAT_CNT   = WAIT_W'(TREE_LAT);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         lane_cnt;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [LANES*NIB_W-1:0]   lane_sr;
  logic [LANES*NIB_W-1:0]   next_vec;
  logic                     in_xfer;
  logic                     vec_done;

  // Staged lanes with the arriving nibble merged in; lanes not yet written
  // are zero because the staging register is cleared after every vector.
  always_comb begin
    in_xfer  = in_valid & in_ready;
`ifdef TW_ZERO_PAD_EN
    vec_done = in_xfer & ((lane_cnt == LAST_LANE) | in_last);
`else
    vec_done = in_xfer & (lane_cnt == LAST_LANE);
`endif
    next_vec = lane_sr;
    next_vec[lane_cnt*NIB_W +: NIB_W] = in_data;
  end

  // Sequencer: fill lanes, wait for the tree, hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FILL;
      lane_cnt  <= '0;
      wait_cnt  <= '0;
      lane_sr   <= '0;
      tw_bus    <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_FILL: begin
          if (vec_done) begin
            tw_bus   <= next_vec;
            lane_sr  <= '0;
            lane_cnt <= '0;
            wait_cnt <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_WAIT;
          end else if (in_xfer) begin
            lane_sr  <= next_vec;
            lane_cnt <= lane_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (wait_cnt == LAT_CNT) begin
            out_sum   <= tree_p;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_FILL;
          end
        end
        default: begin
          state     <= S_FILL;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tw_vector_feeder.sv
// tb_tw_vector_feeder: drives nibble vectors into tw_vector_feeder, models the
// 5-stage adder tree behind tw_bus, and checks packing, latency and results
// against sums computed directly from the stimulus.
module tb_tw_vector_feeder;

  localparam int LANES = 32;
  localparam int NIB_W = 4;
  localparam int SUM_W = 9;
  localparam int BUS_W = LANES * NIB_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [NIB_W-1:0] in_data;
`ifdef TW_ZERO_PAD_EN
  logic             in_last;
`endif
  logic [BUS_W-1:0] tw_bus;
  logic [SUM_W-1:0] tree_p;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NIB_W-1:0] vec [LANES];

  tw_vector_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef TW_ZERO_PAD_EN
    .in_last   (in_last),
`endif
    .tw_bus    (tw_bus),
    .tree_p    (tree_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder tree stand-in: five register stages, reset by the same rst_n.
  logic [SUM_W-1:0] pipe [5];
  function automatic logic [SUM_W-1:0] bus_sum(input logic [BUS_W-1:0] b);
    int unsigned s = 0;
    for (int i = 0; i < LANES; i++) s += b[i*NIB_W +: NIB_W];
    return SUM_W'(s);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= bus_sum(tw_bus);
      for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign tree_p = pipe[4];

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs,
                     input logic [BUS_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Feed vec[0..n-1]; gap_mode 0 = none, 1 = every third cycle idle, 2 = random idles.
  task automatic send_nibbles(input int n, input int gap_mode);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if ((gap_mode == 1 && c % 3 == 2) ||
          (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        in_valid  = 1'b0;
        in_data   = NIB_W'($urandom);
        out_ready = 1'($urandom);
        tick();
        c++;
      end
      in_valid  = 1'b1;
      in_data   = vec[i];
      out_ready = 1'($urandom);
`ifdef TW_ZERO_PAD_EN
      in_last   = (i == n - 1 && n < LANES) ? 1'b1 : 1'($urandom_range(0, 1) & (i == LANES - 1));
`endif
      tick();
      c++;
    end
    in_valid = 1'($urandom);
    in_data  = NIB_W'($urandom);
`ifdef TW_ZERO_PAD_EN
    in_last  = 1'b0;
`endif
  endtask

  task automatic run_vector(input int n, input int gap_mode, input int hold);
    logic [BUS_W-1:0] exp_bus = '0;
    int unsigned exp_sum = 0;
    int k = 0;
    for (int i = 0; i < n; i++) begin
      exp_bus[i*NIB_W +: NIB_W] = vec[i];
      exp_sum += vec[i];
    end
    chk("idle_in_ready", in_ready, 1);
    send_nibbles(n, gap_mode);
    chk("bus_load", tw_bus, exp_bus);
    chk("wait_busy", busy, 1);
    chk("wait_in_ready", in_ready, 0);
    while (!out_valid && k < 20) begin
      tick();
      k++;
      in_valid  = 1'($urandom);
      in_data   = NIB_W'($urandom);
      out_ready = 1'($urandom);
    end
    out_ready = 1'b0;
    chk("latency", k, 6);
    chk("sum", out_sum, exp_sum);
    chk("bus_held", tw_bus, exp_bus);
    for (int h = 0; h < hold; h++) begin
      tick();
      in_valid = 1'($urandom);
      in_data  = NIB_W'($urandom);
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, exp_sum);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_busy", busy, 0);
    chk("bus_after_release", tw_bus, exp_bus);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef TW_ZERO_PAD_EN
    in_last   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_tw_bus", tw_bus, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // All 15s, continuous valid.
    for (int i = 0; i < LANES; i++) vec[i] = 4'hF;
    run_vector(LANES, 0, 0);

    // Lane i = i mod 16 with an idle cycle every third cycle.
    for (int i = 0; i < LANES; i++) vec[i] = NIB_W'(i % 16);
    run_vector(LANES, 1, 0);
    chk("lane5", tw_bus[23:20], 5);

    // All 1s, consumer stalls 10 cycles.
    for (int i = 0; i < LANES; i++) vec[i] = 4'h1;
    run_vector(LANES, 0, 10);

    // Back-to-back 7s then 2s.
    for (int i = 0; i < LANES; i++) vec[i] = 4'h7;
    run_vector(LANES, 0, 0);
    for (int i = 0; i < LANES; i++) vec[i] = 4'h2;
    run_vector(LANES, 0, 0);

    // Reset during WAIT discards the in-flight vector.
    for (int i = 0; i < LANES; i++) vec[i] = 4'h9;
    send_nibbles(LANES, 0);
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sum", out_sum, 0);
    chk("midrst_tw_bus", tw_bus, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    for (int i = 0; i < LANES; i++) vec[i] = 4'h3;
    run_vector(LANES, 0, 0);

`ifdef TW_ZERO_PAD_EN
    // Early completion zero-fills the upper lanes.
    vec[0] = 4'h1; vec[1] = 4'h2; vec[2] = 4'h3;
    run_vector(3, 0, 0);
`endif

    // Random vectors, random gaps and consumer stalls.
    for (int r = 0; r < 8; r++) begin
      int n = LANES;
`ifdef TW_ZERO_PAD_EN
      n = $urandom_range(1, LANES);
`endif
      for (int i = 0; i < LANES; i++) vec[i] = NIB_W'($urandom);
      run_vector(n, 2, $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
